// File: rtl/planificador_ascensor.sv
// SCAN request scheduler for a four-floor elevator: latches button presses,
// picks the next target floor and sequences motor and door commands.
module planificador_ascensor #(
  parameter int unsigned PUERTA_CICLOS = 8,
  parameter int unsigned ANCHO_CONT    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] boton,
  input  logic [1:0] piso,
  output logic       subir,
  output logic       bajar,
  output logic       puerta_abierta,
  output logic [1:0] destino,
  output logic [3:0] pendientes,
  output logic       ocupado
);

  typedef enum logic [1:0] {
    REPOSO,
    SUBIENDO,
    BAJANDO,
    PUERTA
  } estado_t;

  localparam logic [ANCHO_CONT-1:0] CARGA = ANCHO_CONT'(PUERTA_CICLOS - 1);

  estado_t               estado, estado_sig;
  logic                  dir, dir_sig;
  logic [ANCHO_CONT-1:0] cont, cont_sig;
  logic [3:0]            pend_sig;
  logic                  arriba, abajo, recarga;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= REPOSO;
      dir        <= 1'b1;
      cont       <= '0;
      pendientes <= '0;
    end else begin
      estado     <= estado_sig;
      dir        <= dir_sig;
      cont       <= cont_sig;
      pendientes <= pend_sig;
    end
  end

  always_comb begin
    arriba = 1'b0;
    abajo  = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pendientes[i] && (i > 32'(piso))) arriba = 1'b1;
      if (pendientes[i] && (i < 32'(piso))) abajo  = 1'b1;
    end
  end

  // Serving the current floor clears its bit after the OR, so a press there is absorbed.
  always_comb begin
    pend_sig = pendientes | boton;
    if (estado == PUERTA) pend_sig[piso] = 1'b0;
  end

  assign recarga = (estado == PUERTA) && boton[piso];

  always_comb begin
    estado_sig = estado;
    dir_sig    = dir;
    cont_sig   = cont;
    unique case (estado)
      REPOSO: begin
        if (pendientes[piso]) begin
          estado_sig = PUERTA;
          cont_sig   = CARGA;
        end else if (arriba && abajo) begin
          estado_sig = dir ? SUBIENDO : BAJANDO;
        end else if (arriba) begin
          estado_sig = SUBIENDO;
          dir_sig    = 1'b1;
        end else if (abajo) begin
          estado_sig = BAJANDO;
          dir_sig    = 1'b0;
        end
      end
      SUBIENDO: begin
        if (pendientes[piso]) begin
          estado_sig = PUERTA;
          cont_sig   = CARGA;
        end else if (!arriba) begin
          estado_sig = REPOSO;
        end
      end
      BAJANDO: begin
        if (pendientes[piso]) begin
          estado_sig = PUERTA;
          cont_sig   = CARGA;
        end else if (!abajo) begin
          estado_sig = REPOSO;
        end
      end
      PUERTA: begin
        if (recarga) begin
          cont_sig = CARGA;
        end else if (cont != '0) begin
          cont_sig = cont - ANCHO_CONT'(1);
        end else if (dir && arriba) begin
          estado_sig = SUBIENDO;
        end else if (!dir && abajo) begin
          estado_sig = BAJANDO;
        end else if (arriba) begin
          estado_sig = SUBIENDO;
          dir_sig    = 1'b1;
        end else if (abajo) begin
          estado_sig = BAJANDO;
          dir_sig    = 1'b0;
        end else begin
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Nearest pending floor in the travel direction; scans overwrite so the last hit wins.
  always_comb begin
    destino = piso;
    if (estado == SUBIENDO) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (pendientes[3 - k] && ((3 - k) > 32'(piso))) destino = 2'(3 - k);
      end
    end else if (estado == BAJANDO) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (pendientes[k] && (k < 32'(piso))) destino = 2'(k);
      end
    end
  end

  assign subir          = (estado == SUBIENDO);
  assign bajar          = (estado == BAJANDO);
  assign puerta_abierta = (estado == PUERTA);
  assign ocupado        = (estado != REPOSO);

endmodule

// File: tb/tb_planificador_ascensor.sv
// Directed bench for planificador_ascensor: reset, travel, SCAN ordering,
// door timing, current-floor presses and direction ties.
module tb_planificador_ascensor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] boton;
  logic [1:0] piso;
  logic       subir, bajar, puerta_abierta, ocupado;
  logic [1:0] destino;
  logic [3:0] pendientes;

  int assertions = 0;
  int failures   = 0;

  planificador_ascensor #(.PUERTA_CICLOS(8), .ANCHO_CONT(8)) dut (
    .clk(clk), .reset(reset), .boton(boton), .piso(piso),
    .subir(subir), .bajar(bajar), .puerta_abierta(puerta_abierta),
    .destino(destino), .pendientes(pendientes), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; boton = '0; piso = 2'd0;
    #1;
    assertions++; if ({subir, bajar, puerta_abierta, ocupado} !== 4'b0000) begin failures++; $display("FAIL reset_outputs: got %b expected 0000", {subir, bajar, puerta_abierta, ocupado}); end
    assertions++; if (pendientes !== 4'b0000) begin failures++; $display("FAIL reset_pend: got %b expected 0000", pendientes); end
    assertions++; if (destino !== 2'd0) begin failures++; $display("FAIL reset_destino: got %0d expected 0", destino); end
    tick(); tick();
    reset = 1'b0;
    tick();
    assertions++; if (ocupado !== 1'b0) begin failures++; $display("FAIL reset_release_idle: got %b expected 0", ocupado); end
  endtask

  task automatic test_reset_mid_travel();
    piso = 2'd0; boton = 4'b1010;
    tick();
    boton = '0;
    assertions++; if (pendientes !== 4'b1010) begin failures++; $display("FAIL mid_pend_latch: got %b expected 1010", pendientes); end
    tick();
    assertions++; if (subir !== 1'b1 || destino !== 2'd1) begin failures++; $display("FAIL mid_travel: got subir=%b destino=%0d expected subir=1 destino=1", subir, destino); end
    reset = 1'b1;
    #1;
    assertions++; if ({subir, bajar, puerta_abierta, ocupado, destino, pendientes} !== 10'd0) begin failures++; $display("FAIL mid_async_reset: got %b expected all zero", {subir, bajar, puerta_abierta, ocupado, destino, pendientes}); end
    tick();
    reset = 1'b0;
    tick();
    assertions++; if (ocupado !== 1'b0 || pendientes !== 4'b0000) begin failures++; $display("FAIL mid_after_release: got ocupado=%b pend=%b expected 0 0000", ocupado, pendientes); end
  endtask

  task automatic test_single_up();
    int n;
    piso = 2'd0; boton = 4'b0100;
    tick();
    boton = '0;
    assertions++; if (pendientes !== 4'b0100 || ocupado !== 1'b0) begin failures++; $display("FAIL up_latch: got pend=%b ocupado=%b expected 0100 0", pendientes, ocupado); end
    tick();
    assertions++; if (subir !== 1'b1 || bajar !== 1'b0 || destino !== 2'd2) begin failures++; $display("FAIL up_start: got subir=%b bajar=%b destino=%0d expected 1 0 2", subir, bajar, destino); end
    piso = 2'd1;
    tick();
    assertions++; if (subir !== 1'b1 || destino !== 2'd2) begin failures++; $display("FAIL up_hold: got subir=%b destino=%0d expected 1 2", subir, destino); end
    piso = 2'd2;
    tick();
    assertions++; if (puerta_abierta !== 1'b1 || subir !== 1'b0) begin failures++; $display("FAIL up_arrive: got puerta=%b subir=%b expected 1 0", puerta_abierta, subir); end
    n = 0;
    while (puerta_abierta && n < 20) begin n++; tick(); end
    assertions++; if (n !== 8) begin failures++; $display("FAIL up_door_cycles: got %0d expected 8", n); end
    assertions++; if (pendientes !== 4'b0000 || ocupado !== 1'b0) begin failures++; $display("FAIL up_done: got pend=%b ocupado=%b expected 0000 0", pendientes, ocupado); end
  endtask

  task automatic test_scan();
    int n;
    piso = 2'd1;
    tick();
    boton = 4'b1001;
    tick();
    boton = '0;
    assertions++; if (pendientes !== 4'b1001) begin failures++; $display("FAIL scan_latch: got %b expected 1001", pendientes); end
    tick();
    assertions++; if (subir !== 1'b1 || destino !== 2'd3) begin failures++; $display("FAIL scan_up_first: got subir=%b destino=%0d expected 1 3", subir, destino); end
    piso = 2'd2;
    tick();
    piso = 2'd3;
    tick();
    assertions++; if (puerta_abierta !== 1'b1) begin failures++; $display("FAIL scan_stop3: got %b expected 1", puerta_abierta); end
    n = 0;
    while (puerta_abierta && n < 20) begin n++; tick(); end
    assertions++; if (n !== 8) begin failures++; $display("FAIL scan_door3_cycles: got %0d expected 8", n); end
    assertions++; if (bajar !== 1'b1 || subir !== 1'b0 || destino !== 2'd0 || pendientes !== 4'b0001) begin failures++; $display("FAIL scan_reverse: got bajar=%b subir=%b destino=%0d pend=%b expected 1 0 0 0001", bajar, subir, destino, pendientes); end
    piso = 2'd2;
    tick();
    piso = 2'd1;
    tick();
    piso = 2'd0;
    tick();
    assertions++; if (puerta_abierta !== 1'b1 || bajar !== 1'b0) begin failures++; $display("FAIL scan_stop0: got puerta=%b bajar=%b expected 1 0", puerta_abierta, bajar); end
    n = 0;
    while (puerta_abierta && n < 20) begin n++; tick(); end
    assertions++; if (n !== 8 || ocupado !== 1'b0 || pendientes !== 4'b0000) begin failures++; $display("FAIL scan_done: got cycles=%0d ocupado=%b pend=%b expected 8 0 0000", n, ocupado, pendientes); end
  endtask

  task automatic test_tie();
    piso = 2'd1;
    tick();
    boton = 4'b1001;
    tick();
    boton = '0;
    tick();
    assertions++; if (bajar !== 1'b1 || subir !== 1'b0 || destino !== 2'd0) begin failures++; $display("FAIL tie_follow_dir: got bajar=%b subir=%b destino=%0d expected 1 0 0", bajar, subir, destino); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_current_floor();
    int n;
    piso = 2'd2; boton = 4'b0100;
    tick();
    boton = '0;
    tick();
    assertions++; if (puerta_abierta !== 1'b1 || subir !== 1'b0 || bajar !== 1'b0) begin failures++; $display("FAIL cur_open: got puerta=%b subir=%b bajar=%b expected 1 0 0", puerta_abierta, subir, bajar); end
    repeat (4) tick();
    assertions++; if (puerta_abierta !== 1'b1) begin failures++; $display("FAIL cur_before_reload: got %b expected 1", puerta_abierta); end
    boton = 4'b0100;
    tick();
    boton = '0;
    assertions++; if (pendientes !== 4'b0000 || puerta_abierta !== 1'b1) begin failures++; $display("FAIL cur_absorbed: got pend=%b puerta=%b expected 0000 1", pendientes, puerta_abierta); end
    n = 0;
    while (puerta_abierta && n < 20) begin n++; tick(); end
    assertions++; if (n !== 8) begin failures++; $display("FAIL cur_reload_cycles: got %0d expected 8", n); end
    assertions++; if (ocupado !== 1'b0 || pendientes !== 4'b0000) begin failures++; $display("FAIL cur_done: got ocupado=%b pend=%b expected 0 0000", ocupado, pendientes); end
  endtask

  task automatic test_idle_floor();
    int  n;
    logic motor;
    piso = 2'd3; boton = 4'b1000;
    tick();
    boton = '0;
    assertions++; if (subir !== 1'b0 || bajar !== 1'b0 || pendientes !== 4'b1000) begin failures++; $display("FAIL idle_latch: got subir=%b bajar=%b pend=%b expected 0 0 1000", subir, bajar, pendientes); end
    tick();
    assertions++; if (puerta_abierta !== 1'b1 || destino !== 2'd3) begin failures++; $display("FAIL idle_open: got puerta=%b destino=%0d expected 1 3", puerta_abierta, destino); end
    n = 0; motor = 1'b0;
    while (puerta_abierta && n < 20) begin
      if (subir || bajar) motor = 1'b1;
      n++; tick();
    end
    if (subir || bajar) motor = 1'b1;
    assertions++; if (motor !== 1'b0) begin failures++; $display("FAIL idle_no_motor: got %b expected 0", motor); end
    assertions++; if (n !== 8 || ocupado !== 1'b0) begin failures++; $display("FAIL idle_done: got cycles=%0d ocupado=%b expected 8 0", n, ocupado); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_travel();
    test_single_up();
    test_scan();
    test_tie();
    test_current_floor();
    test_idle_floor();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
